// File: rtl/svi_byte_fifo.sv
// First-word-fall-through byte FIFO with level/full/empty status and a sticky drop flag.
// Optional push counter and high-water mark are built only when SVI_FIFO_STATS_EN is defined.
module svi_byte_fifo #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_drop,
    output logic [15:0]   o_wr_count,
    output logic [LW-1:0] o_hwm
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } state_t;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_drop;
    state_t        r_state;
    state_t        w_state_next;
    logic [LW-1:0] w_level_next;
    logic          w_full;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;

    // Status derives only from registered state, so no input reaches an output combinationally.
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_valid = (r_state == ST_NONEMPTY);
    assign w_push  = i_valid && !w_full;
    assign w_pop   = w_valid && i_ready;

    always_comb begin
        w_level_next = r_level;
        w_state_next = r_state;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LW'(1);
        end
        if (w_level_next == '0) begin
            w_state_next = ST_EMPTY;
        end else begin
            w_state_next = ST_NONEMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_level <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (i_valid && w_full) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Storage is left untouched by reset; the cleared pointers make old entries unreachable.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = w_valid;
    assign o_ready = !w_full;
    assign o_full  = w_full;
    assign o_empty = (r_state == ST_EMPTY);
    assign o_level = r_level;
    assign o_drop  = r_drop;

`ifdef SVI_FIFO_STATS_EN
    logic [15:0]   r_wr_count;
    logic [LW-1:0] r_hwm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_count <= '0;
            r_hwm      <= '0;
        end else begin
            if (w_push && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_level_next > r_hwm) begin
                r_hwm <= w_level_next;
            end
        end
    end

    assign o_wr_count = r_wr_count;
    assign o_hwm      = r_hwm;
`else
    assign o_wr_count = '0;
    assign o_hwm      = '0;
`endif

endmodule

// File: tb/tb_svi_byte_fifo.sv
// Directed self-checking bench for svi_byte_fifo (default DEPTH=8, DW=8).
module tb_svi_byte_fifo;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [LW-1:0] o_level;
    logic          o_full;
    logic          o_empty;
    logic          o_drop;
    logic [15:0]   o_wr_count;
    logic [LW-1:0] o_hwm;

    int checks = 0;
    int errors = 0;
    int rd_cnt;

    always #5 clk = ~clk;

    svi_byte_fifo dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_drop     (o_drop),
        .o_wr_count (o_wr_count),
        .o_hwm      (o_hwm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_stats(input string tag, input int wr, input int hwm);
`ifdef SVI_FIFO_STATS_EN
        chk({tag, "_wrcnt"}, 32'(o_wr_count), 32'(wr));
        chk({tag, "_hwm"}, 32'(o_hwm), 32'(hwm));
`else
        chk({tag, "_wrcnt"}, 32'(o_wr_count), 32'd0);
        chk({tag, "_hwm"}, 32'(o_hwm), 32'd0);
`endif
    endtask

    initial begin
        i_rst   = 1'b1;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset and idle
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_drop",  32'(o_drop),  32'd0);
        chk_stats("rst", 0, 0);

        // Two pushes with consumer stalled
        i_valid = 1'b1;
        i_data  = 8'hA5;
        tick();
        chk("lat1_valid", 32'(o_valid), 32'd1);
        chk("lat1_data",  32'(o_data),  32'hA5);
        i_data = 8'h3C;
        tick();
        i_valid = 1'b0;
        chk("two_level", 32'(o_level), 32'd2);
        chk("two_head",  32'(o_data),  32'hA5);
        tick();
        chk("stall_data", 32'(o_data), 32'hA5);
        i_ready = 1'b1;
        chk("pop1_data", 32'(o_data), 32'hA5);
        tick();
        chk("pop2_data", 32'(o_data), 32'h3C);
        tick();
        i_ready = 1'b0;
        chk("pop_empty", 32'(o_empty), 32'd1);
        chk("pop_valid", 32'(o_valid), 32'd0);
        chk_stats("two", 2, 2);

        // Fill with constant bytes beyond capacity
        i_valid = 1'b1;
        i_data  = 8'hFF;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            if (i == DEPTH - 2) chk("fill_notfull", 32'(o_full), 32'd0);
            if (i == DEPTH - 1) begin
                chk("fill_full",    32'(o_full),  32'd1);
                chk("fill_nordy",   32'(o_ready), 32'd0);
                chk("fill_nodrop",  32'(o_drop),  32'd0);
            end
        end
        chk("full_level", 32'(o_level), 32'd8);
        chk("full_drop",  32'(o_drop),  32'd1);

        // Simultaneous push/pop at full: pop only
        i_data  = 8'h11;
        i_ready = 1'b1;
        chk("fullpp_data", 32'(o_data), 32'hFF);
        tick();
        chk("fullpp_level", 32'(o_level), 32'd7);
        chk("fullpp_ready", 32'(o_ready), 32'd1);
        chk("fullpp_data2", 32'(o_data), 32'hFF);
        tick();
        chk("pp7_level", 32'(o_level), 32'd7);
        i_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("drain_valid", 32'(o_valid), 32'd1);
            chk("drain_data", 32'(o_data), (i < 6) ? 32'hFF : 32'h11);
            tick();
        end
        i_ready = 1'b0;
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_drop",  32'(o_drop),  32'd1);
        chk_stats("fill", 11, 8);

        // Reset clears the sticky flag and stats
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst2_drop", 32'(o_drop), 32'd0);
        chk_stats("rst2", 0, 0);

        // Streaming at full rate, pointers wrap twice
        i_ready = 1'b1;
        rd_cnt  = 0;
        for (int i = 0; i < 21; i++) begin
            i_valid = (i < 20);
            i_data  = 8'(i);
            chk("strm_valid", 32'(o_valid), (i > 0) ? 32'd1 : 32'd0);
            if (o_valid) begin
                chk("strm_data", 32'(o_data), 32'(rd_cnt));
                rd_cnt++;
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("strm_count", 32'(rd_cnt), 32'd20);
        chk("strm_empty", 32'(o_empty), 32'd1);
        chk_stats("strm", 20, 1);

        // Reset with 5 bytes buffered
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = 8'h40 + 8'(i);
            tick();
        end
        i_valid = 1'b0;
        chk("pre_level", 32'(o_level), 32'd5);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mid_level", 32'(o_level), 32'd0);
        chk("mid_valid", 32'(o_valid), 32'd0);
        chk("mid_drop",  32'(o_drop),  32'd0);
        chk("mid_empty", 32'(o_empty), 32'd1);
        i_valid = 1'b1;
        i_data  = 8'h77;
        tick();
        i_valid = 1'b0;
        chk("post_valid", 32'(o_valid), 32'd1);
        chk("post_data",  32'(o_data),  32'h77);
        chk("post_level", 32'(o_level), 32'd1);
        chk_stats("post", 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/svi_byte_fifo.md
# svi_byte_fifo

Buffering stage that sits directly downstream of the 8-bit packed-struct producer and consumes its `o_a` byte output. Accepts bytes under a valid/ready handshake, holds up to DEPTH entries in a first-word-fall-through FIFO, and presents them to the next consumer with its own valid/ready pair. Provides level, full, and empty status, plus a sticky flag for bytes the producer offered while the FIFO could not accept them.

## Interface
- DEPTH, 8: number of entries. Must be a power of two, minimum 2.
- DW, 8: data width. It matches the producer's packed byte.
- LW, $clog2(DEPTH)+1: level width. This is a derived localparam and is not overridable.

- i_clk  input  1  sole clock; all state updates on its rising edge
- i_rst  input  1  reset, synchronous and active-high
- i_data  input  DW  byte from upstream producer (`o_a`)
- i_valid  input  1  upstream offers i_data this cycle
- o_ready  output  1  FIFO accepts a byte this cycle; equal to !o_full
- o_data  output  DW  head-of-FIFO byte
- o_valid  output  1  o_data holds a valid byte
- i_ready  input  1  downstream takes o_data this cycle
- o_level  output  LW  current occupancy, 0..DEPTH
- o_full  output  1  o_level == DEPTH
- o_empty  output  1  o_level == 0
- o_drop  output  1  sticky: set when i_valid && !o_ready
- o_wr_count  output  16  accepted-byte counter (see Configuration)
- o_hwm  output  LW  high-water mark of o_level (see Configuration)

## Operation
- Push: occurs when i_valid && o_ready. i_data is written at the write pointer, and wptr increments modulo DEPTH.
- Pop: occurs when o_valid && i_ready. rptr increments modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate LW-bit counter, not inferred from the pointers.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Full: o_ready = 0, so a push is refused even if a pop happens in the same cycle. There is no pass-through at full.
- Empty: o_valid = 0, so no pop is possible. A push into an empty FIFO becomes visible on o_data/o_valid the following cycle.
- o_data is the memory entry at rptr. It is stable while o_valid && !i_ready.
- o_drop sets on any cycle with i_valid && !o_ready. It clears only on i_rst.
- Reset mid-operation: on the cycle i_rst is sampled high, all buffered bytes are discarded.
  - pointers, level, o_drop, and counters all return to 0
  - memory contents are not cleared, but are unreachable
- There are two internal states, EMPTY and NONEMPTY, decoded from the level. Full is a sub-condition of NONEMPTY.

## Timing
- Reset values: o_ready = 1, o_valid = 0, o_empty = 1, o_full = 0, o_level = 0, o_drop = 0, o_wr_count = 0, o_hwm = 0. o_data is don't-care while o_valid = 0.
- Write-to-read latency is 1 cycle: a byte pushed at edge N has o_valid = 1 after edge N.
- All status outputs are registered or decoded from registered level only. There is no combinational path from i_valid or i_ready to any output.
- Sustained throughput is 1 byte per cycle when both sides are ready, at any level from 1 to DEPTH−1.

## Configuration
- Macro: SVI_FIFO_STATS_EN.
- Defined:
  - o_wr_count increments on every push and saturates at 16'hFFFF.
  - o_hwm updates to o_level whenever the next level exceeds it.
  - Both clear on i_rst.
- Undefined:
  - o_wr_count and o_hwm are tied to 0 and no counter logic is built.
  - The port list is identical in both builds.

## Test plan
- Reset, then idle 4 cycles → o_empty=1, o_ready=1, o_valid=0, o_level=0, o_drop=0.
- Push 8'hA5, 8'h3C with i_ready=0 → o_level=2, o_data=8'hA5. Assert i_ready for 2 cycles → 8'hA5 then 8'h3C out, o_empty=1.
- Hold i_valid=1 with constant 8'hFF (producer constant output) and i_ready=0 for DEPTH+2 cycles → o_full=1 after DEPTH pushes, o_drop=1, o_level=8. Then drain → 8 × 8'hFF out in order.
- At full with i_valid=1 and i_ready=1 on the same cycle → pop accepted, push refused, o_level=7. Next cycle o_ready=1 and the push is accepted, o_level stays 7.
- Stream 20 incrementing bytes with both sides ready → pointers wrap twice, output is 0..19 in order with no gaps. With SVI_FIFO_STATS_EN: o_wr_count=20, o_hwm=1.
- Assert i_rst with o_level=5 → next cycle o_level=0, o_valid=0, o_drop=0. The first byte pushed afterwards is the first byte read.
